// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared types and helpers for the perf_mon_multi monitor.
//   state_e     - run-window FSM state (IDLE=0, RUN=1, DONE=2).
//   perf_idx_w  - width of the read index for a given channel count.
//   sat_inc     - saturating increment on a value with a given all-ones limit.
// Optional feature macro: PERF_MON_PEAK_EN (adds peak-streak registers,
// which doubles the readable index space).
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index 0 is the cycle counter, 1..num_ch the event channels, and with the
  // peak feature num_ch+1..2*num_ch the per-channel peaks.
  function automatic int perf_idx_w(input int num_ch);
`ifdef PERF_MON_PEAK_EN
    return $clog2(2 * num_ch + 1);
`else
    return $clog2(num_ch + 1);
`endif
  endfunction

  typedef struct packed {
    logic        hit;  // increment requested while already at the limit
    logic [63:0] val;  // next value (held at the limit on hit)
  } sat_res_t;

  function automatic sat_res_t sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    sat_res_t r;
    if (val == max_val) begin
      r.hit = 1'b1;
      r.val = val;
    end else begin
      r.hit = 1'b0;
      r.val = val + 64'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/perf_sat_cnt.sv
// perf_sat_cnt: CNT_W-bit saturating counter with sticky overflow flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr_i      - synchronous clear of count and flag (wins over inc_i)
//   inc_i      - increment request for this cycle
//   cnt_o      - current count
//   ovf_o      - set when an increment arrives while the count is all-ones
// Used by perf_mon_multi; no dependence on PERF_MON_PEAK_EN.
module perf_sat_cnt
  import perf_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [63:0] MAX_V = {64{1'b1}} >> (64 - CNT_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  sat_res_t         res;

  always_comb begin
    res   = sat_inc(64'(cnt_q), MAX_V);
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      cnt_d = res.val[CNT_W-1:0];
      ovf_d = ovf_q | res.hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_mon_multi.sv
// perf_mon_multi: cycle counter (index 0) plus NUM_CH qualified event
// counters (indices 1..NUM_CH), counting only while the run window is open.
//   clk, rst_n       - clock, asynchronous active-low reset
//   clr              - synchronous clear of counters, ovf flags and FSM
//   start, stop      - run-window open / close pulses
//   evt[NUM_CH]      - per-channel event qualifiers
//   rd_val/rd_rdy    - read request handshake, rd_idx selects the counter
//   rdo_val/rdo_rdy  - read response handshake, rdo_data / rdo_err
//   busy, done       - FSM in RUN / in DONE (together they expose the state)
//   ovf[NUM_CH:0]    - sticky saturation flags, bit k for counter k
// Handshake rule: a transfer happens on a cycle where valid and ready are
// both high at the clock edge; a valid response is held unchanged until it
// transfers, and ready never depends on the same-cycle valid of the sender.
// Optional feature macro: PERF_MON_PEAK_EN adds per-channel streak counters
// and peak registers readable at NUM_CH+1+i.
module perf_mon_multi
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = perf_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_CH-1:0] evt,
  input  logic              rd_val,
  output logic              rd_rdy,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rdo_val,
  input  logic              rdo_rdy,
  output logic [CNT_W-1:0]  rdo_data,
  output logic              rdo_err,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH:0]   ovf
);

  localparam int NCNT = NUM_CH + 1;
`ifdef PERF_MON_PEAK_EN
  localparam int NRD = 2 * NUM_CH + 1;
`else
  localparam int NRD = NUM_CH + 1;
`endif

  // ---------------- run-window FSM ----------------
  state_e state_q, state_d;
  logic   in_run;

  assign in_run = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (stop)  state_d = ST_DONE;
        ST_DONE: if (start) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign busy = in_run;
  assign done = (state_q == ST_DONE);

  // ---------------- counters ----------------
  // Counting follows the registered state, so the start cycle is not counted
  // and the stop cycle is.
  logic [NCNT-1:0]  inc;
  logic [NCNT-1:0]  cnt_ovf;
  logic [CNT_W-1:0] cnt    [NCNT];
  logic [CNT_W-1:0] rd_vals[NRD];

  assign inc = {evt & {NUM_CH{in_run}}, in_run};

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    perf_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .inc_i (inc[g]),
      .cnt_o (cnt[g]),
      .ovf_o (cnt_ovf[g])
    );
    assign rd_vals[g] = cnt[g];
  end

  assign ovf = cnt_ovf;

`ifdef PERF_MON_PEAK_EN
  // Streak counts consecutive RUN cycles with the event high; any other cycle
  // restarts it. Peak follows the registered streak, one cycle behind.
  logic [NUM_CH-1:0] streak_inc, streak_clr, streak_ovf;
  logic [CNT_W-1:0]  streak [NUM_CH];
  logic [CNT_W-1:0]  peak_q [NUM_CH];
  logic [CNT_W-1:0]  peak_d [NUM_CH];

  assign streak_inc = evt & {NUM_CH{in_run}};
  assign streak_clr = {NUM_CH{clr}} | ~streak_inc;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_peak
    perf_sat_cnt #(.CNT_W(CNT_W)) u_streak (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (streak_clr[g]),
      .inc_i (streak_inc[g]),
      .cnt_o (streak[g]),
      .ovf_o (streak_ovf[g])
    );
    assign rd_vals[NCNT+g] = peak_q[g];
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      peak_d[k] = peak_q[k];
      if (clr)                      peak_d[k] = '0;
      else if (streak[k] > peak_q[k]) peak_d[k] = streak[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) peak_q[k] <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end
`endif

  // ---------------- read port ----------------
  logic             rdo_val_q, rdo_val_d;
  logic [CNT_W-1:0] rdo_data_q, rdo_data_d;
  logic             rdo_err_q, rdo_err_d;
  logic             accept;
  logic             rd_err_c;
  logic [CNT_W-1:0] rd_data_c;

  assign rd_rdy = !rdo_val_q | rdo_rdy;
  assign accept = rd_val & rd_rdy;

  always_comb begin
    rd_err_c  = (int'(rd_idx) >= NRD);
    rd_data_c = '0;
    for (int k = 0; k < NRD; k++) begin
      if (int'(rd_idx) == k) rd_data_c = rd_vals[k];
    end
  end

  // The response registers are not touched by clr so a pending response is
  // delivered with the value captured at accept.
  always_comb begin
    rdo_val_d  = rdo_val_q;
    rdo_data_d = rdo_data_q;
    rdo_err_d  = rdo_err_q;
    if (accept) begin
      rdo_val_d  = 1'b1;
      rdo_data_d = rd_data_c;
      rdo_err_d  = rd_err_c;
    end else if (rdo_rdy) begin
      rdo_val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdo_val_q  <= 1'b0;
      rdo_data_q <= '0;
      rdo_err_q  <= 1'b0;
    end else begin
      rdo_val_q  <= rdo_val_d;
      rdo_data_q <= rdo_data_d;
      rdo_err_q  <= rdo_err_d;
    end
  end

  assign rdo_val  = rdo_val_q;
  assign rdo_data = rdo_data_q;
  assign rdo_err  = rdo_err_q;

endmodule
